// File: rtl/led_matrix_framebuffer.sv
// Double-buffered 64x32 HUB75 pixel store.
// The producer writes single pixels (or a full-bank clear sweep) into the back
// bank while the scan driver reads upper/lower row pairs from the front bank.
// A requested bank exchange is held until the driver's frame boundary.

// Simple dual-port RAM: one synchronous write port, one registered read port.
// There is no reset on the storage or the read register, so it maps onto block RAM.
module fb_ram #(
  parameter int AW = 11,
  parameter int DW = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic          re,
  input  logic [AW-1:0] ra,
  output logic [DW-1:0] q
);
  logic [DW-1:0] mem [0:(1<<AW)-1];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  // Read port. The output register holds its value while re is low.
  always_ff @(posedge clk) begin
    if (re) q <= mem[ra];
  end
endmodule

module led_matrix_framebuffer #(
  parameter  int WIDTH      = 64,
  parameter  int HEIGHT     = 32,
  parameter  int COLOR_BITS = 3,
  localparam int CW         = $clog2(WIDTH),
  localparam int RW         = $clog2(HEIGHT/2)
) (
  input  logic                  clk_27MHz,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [CW-1:0]         wr_x,
  input  logic [RW:0]           wr_y,
  input  logic [COLOR_BITS-1:0] wr_rgb,
  output logic                  wr_ready,
  input  logic                  clear_req,
  input  logic [COLOR_BITS-1:0] clear_rgb,
  output logic                  clear_busy,
  input  logic                  swap_req,
  output logic                  swap_pending,
  output logic                  front_bank,
  input  logic                  frame_start,
  input  logic                  rd_en,
  input  logic [CW-1:0]         rd_col,
  input  logic [RW-1:0]         rd_row,
  output logic [COLOR_BITS-1:0] rd_rgb1,
  output logic [COLOR_BITS-1:0] rd_rgb2,
  output logic                  rd_valid
);
  localparam int CAW    = RW + CW;   // address width within one bank
  localparam int AW     = CAW + 1;   // {bank, row, col}
  localparam int HALVES = 2;         // index 0 = upper half, 1 = lower half

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                                  state_q, state_d;
  logic                                    clr_start;
  logic [CAW-1:0]                          clr_addr;
  logic [COLOR_BITS-1:0]                   clr_rgb_q;
  logic                                    back_bank;
  logic                                    do_swap;
  logic                                    rd_seen;
  logic                                    rd_vld_q;

  logic [HALVES-1:0]                       ram_we;
  logic [AW-1:0]                           ram_wa;
  logic [COLOR_BITS-1:0]                   ram_wd;
  logic [AW-1:0]                           rd_addr;
  logic [HALVES-1:0][COLOR_BITS-1:0]       ram_q;

  assign back_bank  = ~front_bank;
  assign wr_ready   = (state_q == IDLE);
  assign clear_busy = (state_q == CLEAR);
  // Swaps are only allowed while idle so a clear sweep never lands in the
  // bank that has just become visible.
  assign do_swap    = frame_start && (swap_pending || swap_req) && (state_q == IDLE);

  // FSM state register.
  always_ff @(posedge clk_27MHz or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: IDLE accepts a clear request, CLEAR runs until the last address.
  always_comb begin
    state_d   = state_q;
    clr_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d   = CLEAR;
          clr_start = 1'b1;
        end
      end
      CLEAR: begin
        if (clr_addr == {CAW{1'b1}}) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Clear address counter and latched fill colour.
  always_ff @(posedge clk_27MHz or negedge rst_n) begin
    if (!rst_n) begin
      clr_addr  <= '0;
      clr_rgb_q <= '0;
    end else if (clr_start) begin
      clr_addr  <= '0;
      clr_rgb_q <= clear_rgb;
    end else if (state_q == CLEAR) begin
      clr_addr  <= clr_addr + 1'b1;
    end
  end

  // Bank select and pending-swap flag.
  always_ff @(posedge clk_27MHz or negedge rst_n) begin
    if (!rst_n) begin
      front_bank   <= 1'b0;
      swap_pending <= 1'b0;
    end else if (do_swap) begin
      front_bank   <= ~front_bank;
      swap_pending <= 1'b0;
    end else if (swap_req) begin
      swap_pending <= 1'b1;
    end
  end

  // Write-port mux: the sweep fills both halves at once; otherwise a pixel
  // write goes to the half chosen by the row MSB. Both target the back bank.
  always_comb begin
    ram_we = '0;
    ram_wa = {back_bank, wr_y[RW-1:0], wr_x};
    ram_wd = wr_rgb;
    if (state_q == CLEAR) begin
      ram_we = {HALVES{1'b1}};
      ram_wa = {back_bank, clr_addr};
      ram_wd = clr_rgb_q;
    end else if (wr_en) begin
      ram_we[wr_y[RW]] = 1'b1;
    end
  end

  // Reads use the front bank as registered this cycle, so a read issued
  // alongside a swap still returns pre-swap data.
  assign rd_addr = {front_bank, rd_row, rd_col};

  genvar h;
  generate
    for (h = 0; h < HALVES; h++) begin : g_half
      fb_ram #(.AW(AW), .DW(COLOR_BITS)) u_ram (
        .clk (clk_27MHz),
        .we  (ram_we[h]),
        .wa  (ram_wa),
        .wd  (ram_wd),
        .re  (rd_en),
        .ra  (rd_addr),
        .q   (ram_q[h])
      );
    end
  endgenerate

  // Read valid, plus a flag that keeps the un-reset RAM output register
  // masked to zero until the first read after reset.
  always_ff @(posedge clk_27MHz or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_q <= 1'b0;
      rd_seen  <= 1'b0;
    end else begin
      rd_vld_q <= rd_en;
      if (rd_en) rd_seen <= 1'b1;
    end
  end

  assign rd_valid = rd_vld_q;
  assign rd_rgb1  = rd_seen ? ram_q[0] : '0;
  assign rd_rgb2  = rd_seen ? ram_q[1] : '0;
endmodule

// File: tb/tb_led_matrix_framebuffer.sv
// Scoreboard bench for led_matrix_framebuffer: reads push expected pixel
// pairs into a queue, a negedge monitor pops and compares on rd_valid.
module tb_led_matrix_framebuffer;
  logic       clk_27MHz = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [5:0] wr_x;
  logic [4:0] wr_y;
  logic [2:0] wr_rgb;
  logic       wr_ready;
  logic       clear_req;
  logic [2:0] clear_rgb;
  logic       clear_busy;
  logic       swap_req;
  logic       swap_pending;
  logic       front_bank;
  logic       frame_start;
  logic       rd_en;
  logic [5:0] rd_col;
  logic [3:0] rd_row;
  logic [2:0] rd_rgb1;
  logic [2:0] rd_rgb2;
  logic       rd_valid;

  typedef struct {
    logic [2:0] r1;
    logic [2:0] r2;
    int         col;
    int         row;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  led_matrix_framebuffer dut (
    .clk_27MHz    (clk_27MHz),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .wr_x         (wr_x),
    .wr_y         (wr_y),
    .wr_rgb       (wr_rgb),
    .wr_ready     (wr_ready),
    .clear_req    (clear_req),
    .clear_rgb    (clear_rgb),
    .clear_busy   (clear_busy),
    .swap_req     (swap_req),
    .swap_pending (swap_pending),
    .front_bank   (front_bank),
    .frame_start  (frame_start),
    .rd_en        (rd_en),
    .rd_col       (rd_col),
    .rd_row       (rd_row),
    .rd_rgb1      (rd_rgb1),
    .rd_rgb2      (rd_rgb2),
    .rd_valid     (rd_valid)
  );

  always #18 clk_27MHz = ~clk_27MHz;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: every valid read result is matched against the oldest expectation.
  always @(negedge clk_27MHz) begin
    if (rst_n && rd_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL rd_unexpected: got rgb1=%b rgb2=%b expected no read", rd_rgb1, rd_rgb2);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (rd_rgb1 !== e.r1 || rd_rgb2 !== e.r2) begin
          bad++;
          $display("FAIL rd(%0d,%0d): got rgb1=%b rgb2=%b expected rgb1=%b rgb2=%b",
                   e.col, e.row, rd_rgb1, rd_rgb2, e.r1, e.r2);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_27MHz);
    #1;
  endtask

  task automatic wr(input int x, input int y, input logic [2:0] rgb);
    wr_en = 1'b1; wr_x = x[5:0]; wr_y = y[4:0]; wr_rgb = rgb;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd(input int col, input int row, input logic [2:0] e1, input logic [2:0] e2);
    exp_t e;
    e.r1 = e1; e.r2 = e2; e.col = col; e.row = row;
    exp_q.push_back(e);
    rd_en = 1'b1; rd_col = col[5:0]; rd_row = row[3:0];
    tick();
    rd_en = 1'b0;
  endtask

  task automatic swap_now();
    swap_req = 1'b1; frame_start = 1'b1;
    tick();
    swap_req = 1'b0; frame_start = 1'b0;
  endtask

  // Runs a full clear sweep; optionally pokes a write at busy cycle 5, a
  // swap_req at cycle 10 and a frame_start at cycle 20.
  task automatic sweep(input logic [2:0] rgb, input bit inj_wr, input bit inj_swap,
                       output int cnt, output int rdy_hi);
    clear_req = 1'b1; clear_rgb = rgb;
    tick();
    clear_req = 1'b0;
    cnt = 0; rdy_hi = 0;
    while (clear_busy && cnt < 2000) begin
      if (wr_ready) rdy_hi++;
      wr_en       = inj_wr && (cnt == 5);
      wr_x = 6'd0; wr_y = 5'd0; wr_rgb = 3'b111;
      swap_req    = inj_swap && (cnt == 10);
      frame_start = inj_swap && (cnt == 20);
      clear_req   = (cnt == 30);  // ignored mid-sweep
      tick();
      cnt++;
    end
    wr_en = 1'b0; swap_req = 1'b0; frame_start = 1'b0; clear_req = 1'b0;
  endtask

  initial begin
    int cnt, rdy;
    rst_n = 1'b0; wr_en = 1'b0; wr_x = '0; wr_y = '0; wr_rgb = '0;
    clear_req = 1'b0; clear_rgb = '0; swap_req = 1'b0; frame_start = 1'b0;
    rd_en = 1'b0; rd_col = '0; rd_row = '0;
    repeat (3) @(posedge clk_27MHz);
    #1;
    chk("rst_front_bank", front_bank, 0);
    chk("rst_swap_pending", swap_pending, 0);
    chk("rst_clear_busy", clear_busy, 0);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_rgb1", rd_rgb1, 0);
    chk("rst_rd_rgb2", rd_rgb2, 0);
    rst_n = 1'b1;
    tick();

    // Zero both banks so later reads have known contents.
    sweep(3'b000, 0, 0, cnt, rdy);
    swap_now();
    sweep(3'b000, 0, 0, cnt, rdy);
    swap_now();
    chk("init_front_bank", front_bank, 0);

    // Basic write, immediate swap, read back with hold check.
    wr(5, 3, 3'b101);
    swap_now();
    chk("t1_front_bank", front_bank, 1);
    rd(5, 3, 3'b101, 3'b000);
    chk("t1_rd_valid_hi", rd_valid, 1);
    tick();
    chk("t1_rd_valid_lo", rd_valid, 0);
    chk("t1_rd_hold", rd_rgb1, 3'b101);

    // Swap held pending until frame_start; lower-half corner pixel.
    wr(63, 31, 3'b110);
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    repeat (50) tick();
    chk("t2_pending", swap_pending, 1);
    chk("t2_front_hold", front_bank, 1);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    chk("t2_front_swap", front_bank, 0);
    chk("t2_pending_clr", swap_pending, 0);
    rd(63, 15, 3'b000, 3'b110);

    // Clear sweep timing, dropped write, full-bank readback.
    sweep(3'b010, 1, 0, cnt, rdy);
    chk("t3_busy_cycles", cnt, 1024);
    chk("t3_wr_ready_busy", rdy, 0);
    chk("t3_wr_ready_after", wr_ready, 1);
    swap_now();
    chk("t3_front_bank", front_bank, 1);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 64; c++)
        rd(c, r, 3'b010, 3'b010);

    // Swap requested and frame_start seen during a clear stay pending.
    sweep(3'b111, 0, 1, cnt, rdy);
    chk("t4_busy_cycles", cnt, 1024);
    chk("t4_front_hold", front_bank, 1);
    chk("t4_pending", swap_pending, 1);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    chk("t4_front_swap", front_bank, 0);
    chk("t4_pending_clr", swap_pending, 0);
    rd(10, 7, 3'b111, 3'b111);

    // Read coincident with swap returns old-bank data.
    wr(2, 2, 3'b100);
    swap_req = 1'b1; frame_start = 1'b1;
    rd(2, 2, 3'b111, 3'b111);
    swap_req = 1'b0; frame_start = 1'b0;
    chk("t5_front_bank", front_bank, 1);
    rd(2, 2, 3'b100, 3'b010);

    // Reset in the middle of a clear with a swap pending.
    tick();
    clear_req = 1'b1; clear_rgb = 3'b001; tick(); clear_req = 1'b0;
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    repeat (498) tick();
    chk("t6_busy_before", clear_busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_clear_busy", clear_busy, 0);
    chk("t6_wr_ready", wr_ready, 1);
    chk("t6_front_bank", front_bank, 0);
    chk("t6_swap_pending", swap_pending, 0);
    chk("t6_rd_rgb1", rd_rgb1, 0);
    tick();
    rst_n = 1'b1;
    tick();
    wr(1, 1, 3'b011);
    swap_now();
    rd(1, 1, 3'b011, 3'b010);

    repeat (4) tick();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
